// File: rtl/noc_pkg.sv
// Shared NoC router definitions: address width, default flit/packet
// geometry, the flit type and the port index encoding used by the
// demux/mux selects.
package noc_pkg;

  localparam int YX_ADDR_W   = 16;
  localparam int NOC_FLIT_W  = 32;
  localparam int NOC_PKT_LEN = 4;

  typedef logic [NOC_FLIT_W-1:0] flit_t;

  // Router port index, same 3-bit encoding as the crossbar selects.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_W = 3'd2,
    PORT_E = 3'd3,
    PORT_L = 3'd4
  } port_e;

endpackage

// File: rtl/noc_fifo_mem.sv
// DEPTH x FLIT_W register array: one synchronous write port and one
// asynchronous read port. Contents are never cleared.
module noc_fifo_mem #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [FLIT_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [FLIT_W-1:0] rdata
);

  logic [FLIT_W-1:0] mem [DEPTH];

  // Store the incoming flit at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/noc_input_buffer.sv
// Per-port input FIFO of the 5-port NoC router. Presents the head flit
// (first-word-fall-through), the current packet's YX header address and
// empty/full/count to the arbiter, and returns one credit per popped flit.
// Optional build macro NOC_IB_ERR_EN adds sticky ib_ovf_o / ib_udf_o flags.
//
// Strobe semantics: ib_write_i is a fire-and-forget valid from the link;
// it is accepted when the FIFO is not full or a pop is accepted in the
// same cycle, otherwise the flit is dropped. ib_read_i is accepted only
// when the FIFO is non-empty (no bypass of a same-cycle write); each
// accepted read produces exactly one ib_credit_o pulse in the next cycle.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W  = NOC_FLIT_W,
  parameter int DEPTH   = 4,
  parameter int PKT_LEN = NOC_PKT_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ib_write_i,
  input  logic [FLIT_W-1:0]          ib_data_i,
  input  logic                       ib_read_i,
  output logic [FLIT_W-1:0]          ib_data_o,
  output logic                       ib_empty_o,
  output logic                       ib_full_o,
  output logic [YX_ADDR_W-1:0]       ib_hdr_addr_o,
  output logic                       ib_credit_o,
`ifdef NOC_IB_ERR_EN
  output logic                       ib_ovf_o,
  output logic                       ib_udf_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] ib_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [PW-1:0]        pkt_idx;
  logic [YX_ADDR_W-1:0] hdr_reg;
  logic                 credit;
  logic [FLIT_W-1:0]    head;
  logic                 empty;
  logic                 full;
  logic                 rd_acc;
  logic                 wr_acc;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign rd_acc = ib_read_i && !empty;
  assign wr_acc = ib_write_i && (!full || rd_acc);

  noc_fifo_mem #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (ib_data_i),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
    end
  end

  // Packet position tracker; latches the header address as the header leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_idx <= '0;
      hdr_reg <= '0;
    end else if (rd_acc) begin
      if (pkt_idx == '0) begin
        hdr_reg <= head[YX_ADDR_W-1:0];
      end
      if (pkt_idx == PW'(PKT_LEN - 1)) begin
        pkt_idx <= '0;
      end else begin
        pkt_idx <= pkt_idx + PW'(1);
      end
    end
  end

  // One credit pulse per accepted pop, one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= 1'b0;
    end else begin
      credit <= rd_acc;
    end
  end

`ifdef NOC_IB_ERR_EN
  logic ovf;
  logic udf;

  // Sticky error flags: dropped write and read-while-empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ib_write_i && !wr_acc) ovf <= 1'b1;
      if (ib_read_i && empty)    udf <= 1'b1;
    end
  end

  assign ib_ovf_o = ovf;
  assign ib_udf_o = udf;
`endif

  // Header address: live from the head flit at a packet boundary, held
  // from hdr_reg for the body; zero while idle at a packet boundary so the
  // stale memory word is never presented.
  always_comb begin
    ib_hdr_addr_o = hdr_reg;
    if (pkt_idx == '0) begin
      ib_hdr_addr_o = empty ? '0 : head[YX_ADDR_W-1:0];
    end
  end

  assign ib_data_o   = head;
  assign ib_empty_o  = empty;
  assign ib_full_o   = full;
  assign ib_count_o  = count;
  assign ib_credit_o = credit;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed testbench for noc_input_buffer (DEPTH=4, PKT_LEN=4, FLIT_W=32).
module tb_noc_input_buffer;

  logic        clk;
  logic        reset;
  logic        ib_write_i;
  logic [31:0] ib_data_i;
  logic        ib_read_i;
  logic [31:0] ib_data_o;
  logic        ib_empty_o;
  logic        ib_full_o;
  logic [15:0] ib_hdr_addr_o;
  logic        ib_credit_o;
  logic [2:0]  ib_count_o;
`ifdef NOC_IB_ERR_EN
  logic        ib_ovf_o;
  logic        ib_udf_o;
`endif

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  noc_input_buffer #(
    .FLIT_W  (32),
    .DEPTH   (4),
    .PKT_LEN (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ib_write_i    (ib_write_i),
    .ib_data_i     (ib_data_i),
    .ib_read_i     (ib_read_i),
    .ib_data_o     (ib_data_o),
    .ib_empty_o    (ib_empty_o),
    .ib_full_o     (ib_full_o),
    .ib_hdr_addr_o (ib_hdr_addr_o),
    .ib_credit_o   (ib_credit_o),
`ifdef NOC_IB_ERR_EN
    .ib_ovf_o      (ib_ovf_o),
    .ib_udf_o      (ib_udf_o),
`endif
    .ib_count_o    (ib_count_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ib_write_i = 1'b0; ib_read_i = 1'b0; ib_data_i = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (ib_count_o !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", ib_count_o); end
    checks++; if (ib_empty_o !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", ib_empty_o); end
    checks++; if (ib_full_o !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", ib_full_o); end
    checks++; if (ib_credit_o !== 1'b0) begin failures++; $display("FAIL rst_credit got=%b exp=0", ib_credit_o); end
    checks++; if (ib_hdr_addr_o !== 16'h0) begin failures++; $display("FAIL rst_hdr got=%h exp=0000", ib_hdr_addr_o); end
`ifdef NOC_IB_ERR_EN
    checks++; if (ib_ovf_o !== 1'b0 || ib_udf_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b%b exp=00", ib_ovf_o, ib_udf_o); end
`endif
  endtask

  task automatic test_fill();
    logic [31:0] v [4];
    v[0] = 32'hA000_0102; v[1] = 32'h0000_00B1; v[2] = 32'h0000_00B2; v[3] = 32'h0000_00B3;
    for (int i = 0; i < 4; i++) begin
      ib_write_i = 1'b1; ib_data_i = v[i];
      tick();
      checks++; if (ib_count_o !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, ib_count_o, i + 1); end
      checks++; if (ib_hdr_addr_o !== 16'h0102) begin failures++; $display("FAIL fill_hdr[%0d] got=%h exp=0102", i, ib_hdr_addr_o); end
      checks++; if (ib_full_o !== (i == 3)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, ib_full_o, i == 3); end
    end
    ib_write_i = 1'b0;
    checks++; if (ib_data_o !== 32'hA000_0102) begin failures++; $display("FAIL fill_head got=%h exp=a0000102", ib_data_o); end
  endtask

  task automatic test_overflow();
    ib_write_i = 1'b1; ib_data_i = 32'h0000_DEAD; ib_read_i = 1'b0;
    tick();
    ib_write_i = 1'b0;
    checks++; if (ib_count_o !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", ib_count_o); end
    checks++; if (ib_data_o !== 32'hA000_0102) begin failures++; $display("FAIL ovf_head got=%h exp=a0000102", ib_data_o); end
    checks++; if (ib_full_o !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", ib_full_o); end
    checks++; if (ib_credit_o !== 1'b0) begin failures++; $display("FAIL ovf_credit got=%b exp=0", ib_credit_o); end
`ifdef NOC_IB_ERR_EN
    checks++; if (ib_ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ib_ovf_o); end
    checks++; if (ib_udf_o !== 1'b0) begin failures++; $display("FAIL ovf_udf got=%b exp=0", ib_udf_o); end
`endif
  endtask

  task automatic test_pop();
    logic [31:0] v [4];
    v[0] = 32'hA000_0102; v[1] = 32'h0000_00B1; v[2] = 32'h0000_00B2; v[3] = 32'h0000_00B3;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ib_data_o !== v[i]) begin failures++; $display("FAIL pop_data[%0d] got=%h exp=%h", i, ib_data_o, v[i]); end
      checks++; if (ib_hdr_addr_o !== 16'h0102) begin failures++; $display("FAIL pop_hdr[%0d] got=%h exp=0102", i, ib_hdr_addr_o); end
      ib_read_i = 1'b1;
      tick();
      checks++; if (ib_credit_o !== 1'b1) begin failures++; $display("FAIL pop_credit[%0d] got=%b exp=1", i, ib_credit_o); end
      checks++; if (ib_count_o !== 3'(3 - i)) begin failures++; $display("FAIL pop_count[%0d] got=%0d exp=%0d", i, ib_count_o, 3 - i); end
    end
    ib_read_i = 1'b0;
    checks++; if (ib_empty_o !== 1'b1) begin failures++; $display("FAIL pop_empty got=%b exp=1", ib_empty_o); end
    tick();
    checks++; if (ib_credit_o !== 1'b0) begin failures++; $display("FAIL pop_credit_end got=%b exp=0", ib_credit_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [12];
    logic [31:0] exp_flit;
    logic [15:0] cur_hdr;
    int pops;
    int credits;
    v[0] = 32'hA000_0304; v[1]  = 32'h0000_00C1; v[2]  = 32'h0000_00C2; v[3]  = 32'h0000_00C3;
    v[4] = 32'hA000_0405; v[5]  = 32'h0000_00D1; v[6]  = 32'h0000_00D2; v[7]  = 32'h0000_00D3;
    v[8] = 32'hA000_0506; v[9]  = 32'h0000_00E1; v[10] = 32'h0000_00E2; v[11] = 32'h0000_00E3;
    pops = 0; credits = 0; cur_hdr = '0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      ib_write_i = 1'b1; ib_data_i = v[i]; exp_q.push_back(v[i]);
      tick();
    end
    // 8 cycles of simultaneous push and pop at full, then drain 4.
    for (int i = 0; i < 12; i++) begin
      exp_flit = exp_q.pop_front();
      if (pops % 4 == 0) cur_hdr = exp_flit[15:0];
      checks++; if (ib_data_o !== exp_flit) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, ib_data_o, exp_flit); end
      checks++; if (ib_hdr_addr_o !== cur_hdr) begin failures++; $display("FAIL b2b_hdr[%0d] got=%h exp=%h", i, ib_hdr_addr_o, cur_hdr); end
      ib_read_i = 1'b1;
      if (i < 8) begin
        ib_write_i = 1'b1; ib_data_i = v[i + 4]; exp_q.push_back(v[i + 4]);
      end else begin
        ib_write_i = 1'b0;
      end
      tick();
      pops++;
      if (ib_credit_o === 1'b1) credits++;
      if (i < 8) begin
        checks++; if (ib_count_o !== 3'd4) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=4", i, ib_count_o); end
      end
    end
    ib_read_i = 1'b0; ib_write_i = 1'b0;
    checks++; if (credits !== 12) begin failures++; $display("FAIL b2b_credits got=%0d exp=12", credits); end
    checks++; if (ib_empty_o !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", ib_empty_o); end
    tick();
  endtask

  task automatic test_empty_rw();
    ib_write_i = 1'b1; ib_data_i = 32'hA000_0203; ib_read_i = 1'b1;
    tick();
    ib_write_i = 1'b0; ib_read_i = 1'b0;
    checks++; if (ib_credit_o !== 1'b0) begin failures++; $display("FAIL erw_credit got=%b exp=0", ib_credit_o); end
    checks++; if (ib_empty_o !== 1'b0) begin failures++; $display("FAIL erw_empty got=%b exp=0", ib_empty_o); end
    checks++; if (ib_count_o !== 3'd1) begin failures++; $display("FAIL erw_count got=%0d exp=1", ib_count_o); end
    checks++; if (ib_data_o !== 32'hA000_0203) begin failures++; $display("FAIL erw_data got=%h exp=a0000203", ib_data_o); end
    checks++; if (ib_hdr_addr_o !== 16'h0203) begin failures++; $display("FAIL erw_hdr got=%h exp=0203", ib_hdr_addr_o); end
`ifdef NOC_IB_ERR_EN
    checks++; if (ib_udf_o !== 1'b1) begin failures++; $display("FAIL erw_udf got=%b exp=1", ib_udf_o); end
`endif
  endtask

  task automatic test_reset_mid();
    // FIFO holds header 0x0203; add three body flits, pop two.
    for (int i = 0; i < 3; i++) begin
      ib_write_i = 1'b1; ib_data_i = 32'h0000_00F1 + i;
      tick();
    end
    ib_write_i = 1'b0;
    ib_read_i = 1'b1;
    tick(); tick();
    // Reset with a pop still requested: no credit must come out of it.
    reset = 1'b1;
    tick();
    reset = 1'b0; ib_read_i = 1'b0;
    checks++; if (ib_count_o !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", ib_count_o); end
    checks++; if (ib_empty_o !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%b exp=1", ib_empty_o); end
    checks++; if (ib_credit_o !== 1'b0) begin failures++; $display("FAIL rmid_credit got=%b exp=0", ib_credit_o); end
`ifdef NOC_IB_ERR_EN
    checks++; if (ib_ovf_o !== 1'b0 || ib_udf_o !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b%b exp=00", ib_ovf_o, ib_udf_o); end
`endif
    ib_write_i = 1'b1; ib_data_i = 32'hA000_0607;
    tick();
    ib_write_i = 1'b0;
    checks++; if (ib_hdr_addr_o !== 16'h0607) begin failures++; $display("FAIL rmid_hdr got=%h exp=0607", ib_hdr_addr_o); end
    checks++; if (ib_count_o !== 3'd1) begin failures++; $display("FAIL rmid_count2 got=%0d exp=1", ib_count_o); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; ib_write_i = 1'b0; ib_read_i = 1'b0; ib_data_i = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_pop();
    test_back_to_back();
    test_empty_rw();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
